// File: rtl/bitcol_sparse_scheduler_pkg.sv
// Shared types and constants for the bit-column sparse scheduler.
// Lane grouping and mux window sizes are fixed by the MAC datapath.
package bitsim_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_state_e;

  localparam int GROUP_SIZE      = 8;
  localparam int LANES_PER_GROUP = 4;
  localparam int MUX_WINDOW      = 5;
  localparam int DRAIN_CYCLES    = 2;
  localparam int SEL_W           = $clog2(MUX_WINDOW);

endpackage

// File: rtl/bitcol_sparse_scheduler_group_encoder.sv
// Encodes one 8-bit weight column slice into 4 mux lanes (sel/val) plus the
// add-ones / subtract-zeros choice. Purely combinational.
module bitcol_group_encoder
  import bitsim_sched_pkg::*;
(
  input  logic [GROUP_SIZE-1:0]                 bits,
  output logic [LANES_PER_GROUP-1:0][SEL_W-1:0] sel,
  output logic [LANES_PER_GROUP-1:0]            val,
  output logic                                  skip_zero
);

  always_comb begin
    int k;
    int j;
    int jn;
    logic [GROUP_SIZE-1:0] tgt;
    sel = '0;
    val = '0;
    k   = 0;
    j   = -1;
    jn  = 0;
    for (int p = 0; p < GROUP_SIZE; p++) k += int'(bits[p]);
    skip_zero = (k <= LANES_PER_GROUP);
    tgt = skip_zero ? bits : ~bits;
    // Greedy lane packing: each target takes the lowest free lane whose window still reaches it.
    for (int p = 0; p < GROUP_SIZE; p++) begin
      if (tgt[p]) begin
        jn = j + 1;
        if (p - (MUX_WINDOW - 1) > jn) jn = p - (MUX_WINDOW - 1);
        if (jn < LANES_PER_GROUP) begin
          sel[jn[1:0]] = SEL_W'(p - jn);
          val[jn[1:0]] = 1'b1;
        end
        j = jn;
      end
    end
  end

endmodule

// File: rtl/bitcol_sparse_scheduler.sv
// Control stage of the bit-serial MAC: latches a tile, walks non-empty weight
// bit-columns MSB->LSB, and drives registered mux selects and MAC controls.
module bitcol_sparse_scheduler
  import bitsim_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int VEC_LENGTH     = 16,
  parameter int SUM_ACT_WIDTH  = $clog2(VEC_LENGTH) + DATA_WIDTH - 1,
  parameter bit SKIP_EMPTY_COL = 1'b1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]               act_in,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]               w_in,
  output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]               act,
  output logic [VEC_LENGTH/GROUP_SIZE-1:0][SUM_ACT_WIDTH-1:0] sum_act,
  output logic [VEC_LENGTH/2-1:0][SEL_W-1:0]                  act_sel,
  output logic [VEC_LENGTH/2-1:0]                             act_val,
  output logic [VEC_LENGTH/GROUP_SIZE-1:0]                    is_skip_zero,
  output logic [$clog2(DATA_WIDTH)-1:0]                       column_idx,
  output logic                                                is_msb,
  output logic                                                mac_en,
  output logic                                                load_accum,
  output logic                                                result_valid
);

  localparam int COL_W   = $clog2(DATA_WIDTH);
  localparam int NGROUPS = VEC_LENGTH / GROUP_SIZE;

  sched_state_e state, state_nxt;
  logic [1:0]   drain_cnt, drain_cnt_nxt;
  logic         first_issue, issue, result_valid_nxt, accept;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]          w_q, src_w;
  logic [DATA_WIDTH-1:0]                          col_mask;
  logic [COL_W-1:0]                               next_col;
  logic [VEC_LENGTH-1:0]                          col_bits;
  logic [NGROUPS-1:0][LANES_PER_GROUP-1:0][SEL_W-1:0] enc_sel;
  logic [NGROUPS-1:0][LANES_PER_GROUP-1:0]        enc_val;
  logic [NGROUPS-1:0]                             enc_skip;
  logic [NGROUPS-1:0][SUM_ACT_WIDTH-1:0]          sum_nxt;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // The first column is found straight from w_in so issue starts the cycle after accept.
  always_comb begin : col_search
    logic any;
    src_w    = (state == IDLE) ? w_in : w_q;
    col_mask = '0;
    next_col = '0;
    any      = 1'b0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      any = 1'b0;
      for (int i = 0; i < VEC_LENGTH; i++) any = any | src_w[i][c];
      col_mask[c] = any | (c == 0) | !SKIP_EMPTY_COL;
    end
    for (int c = 0; c < DATA_WIDTH; c++)
      if (col_mask[c] && (state == IDLE || c < int'(column_idx))) next_col = COL_W'(c);
    for (int i = 0; i < VEC_LENGTH; i++) col_bits[i] = src_w[i][next_col];
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_enc
    bitcol_group_encoder u_enc (
      .bits      (col_bits[g*GROUP_SIZE +: GROUP_SIZE]),
      .sel       (enc_sel[g]),
      .val       (enc_val[g]),
      .skip_zero (enc_skip[g])
    );
  end

  always_comb begin : act_sums
    logic signed [SUM_ACT_WIDTH-1:0] acc;
    acc = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      acc = '0;
      for (int j = 0; j < GROUP_SIZE; j++)
        acc = acc + SUM_ACT_WIDTH'($signed(act_in[g*GROUP_SIZE+j]));
      sum_nxt[g] = acc;
    end
  end

  always_comb begin : fsm_next
    state_nxt        = state;
    drain_cnt_nxt    = drain_cnt;
    issue            = 1'b0;
    result_valid_nxt = 1'b0;
    case (state)
      IDLE:
        if (accept) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
      ISSUE:
        if (column_idx == '0) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end else begin
          issue = 1'b1;
        end
      DRAIN:
        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
          state_nxt        = IDLE;
          result_valid_nxt = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + 2'd1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  // Output registers: everything the MAC sees changes only on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      first_issue  <= 1'b0;
      act          <= '0;
      sum_act      <= '0;
      act_sel      <= '0;
      act_val      <= '0;
      is_skip_zero <= '0;
      column_idx   <= '0;
      is_msb       <= 1'b0;
      mac_en       <= 1'b0;
      load_accum   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      drain_cnt    <= drain_cnt_nxt;
      first_issue  <= (state == IDLE) && issue;
      load_accum   <= (state == ISSUE) && first_issue;
      mac_en       <= (state_nxt != IDLE);
      result_valid <= result_valid_nxt;
      if (accept) begin
        act     <= act_in;
        sum_act <= sum_nxt;
      end
      if (issue) begin
        column_idx   <= next_col;
        is_msb       <= (next_col == COL_W'(DATA_WIDTH - 1));
        act_sel      <= enc_sel;
        act_val      <= enc_val;
        is_skip_zero <= enc_skip;
      end else begin
        act_sel      <= '0;
        act_val      <= '0;
        is_msb       <= 1'b0;
        is_skip_zero <= (state_nxt == DRAIN) ? '1 : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) w_q <= w_in;
  end

endmodule

// File: tb/tb_bitcol_sparse_scheduler.sv
// Randomized bench for bitcol_sparse_scheduler: a behavioural bit-serial MAC
// consumes the scheduler outputs and its result is compared with sum(act*w).
module tb_bitcol_sparse_scheduler;

  logic                  clk = 1'b0;
  logic                  reset, in_valid, in_ready;
  logic [15:0][7:0]      act_in, w_in, act;
  logic [1:0][10:0]      sum_act;
  logic [7:0][2:0]       act_sel;
  logic [7:0]            act_val;
  logic [1:0]            is_skip_zero;
  logic [2:0]            column_idx;
  logic                  is_msb, mac_en, load_accum, result_valid;

  int n_cmp = 0;
  int n_bad = 0;

  int tile_act[16];
  int tile_w[16];

  int              cap_len;
  logic [2:0]      cap_col[24];
  logic            cap_msb[24], cap_en[24], cap_ld[24];
  logic [7:0]      cap_val[24];
  logic [1:0]      cap_skip[24];
  logic [7:0][2:0] cap_sel[24];

  always #5 clk = ~clk;

  bitcol_sparse_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .w_in(w_in), .act(act), .sum_act(sum_act),
    .act_sel(act_sel), .act_val(act_val), .is_skip_zero(is_skip_zero),
    .column_idx(column_idx), .is_msb(is_msb), .mac_en(mac_en),
    .load_accum(load_accum), .result_valid(result_valid)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_acts();
    for (int i = 0; i < 16; i++) tile_act[i] = int'($urandom_range(255)) - 128;
  endtask

  // Drives one tile from a negedge, follows it to result_valid and scores it.
  task automatic run_tile(input string name);
    int ecol[$];
    int gold, acc, n, eff, got_len;
    int gsum[2];
    logic [7:0] wb;
    logic any;
    logic [15:0][7:0] exp_act;
    gold = 0; gsum[0] = 0; gsum[1] = 0;
    for (int i = 0; i < 16; i++) begin
      act_in[i]  = 8'(tile_act[i]);
      w_in[i]    = 8'(tile_w[i]);
      exp_act[i] = 8'(tile_act[i]);
      gold += tile_act[i] * tile_w[i];
      gsum[i / 8] += tile_act[i];
    end
    for (int c = 7; c >= 0; c--) begin
      any = 1'b0;
      for (int i = 0; i < 16; i++) begin
        wb = 8'(tile_w[i]);
        if (wb[c]) any = 1'b1;
      end
      if (any || c == 0) ecol.push_back(c);
    end
    n = ecol.size();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready at accept: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1;
    cap_len = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) begin
        in_valid = 1'b0;
        n_cmp++;
        if (act !== exp_act) begin
          n_bad++;
          $display("FAIL %s act register: got %h want %h", name, act, exp_act);
        end
        for (int g = 0; g < 2; g++) begin
          n_cmp++;
          if (int'($signed(sum_act[g])) !== gsum[g]) begin
            n_bad++;
            $display("FAIL %s sum_act[%0d]: got %0d want %0d", name, g, $signed(sum_act[g]), gsum[g]);
          end
        end
      end
      cap_col[k] = column_idx; cap_msb[k] = is_msb; cap_en[k] = mac_en; cap_ld[k] = load_accum;
      cap_val[k] = act_val; cap_skip[k] = is_skip_zero; cap_sel[k] = act_sel;
      if (result_valid === 1'b1) begin
        cap_len = k;
        break;
      end
    end
    got_len = cap_len;
    n_cmp++;
    if (got_len != n + 3) begin
      n_bad++;
      $display("FAIL %s result_valid cycle: got T+%0d want T+%0d", name, got_len, n + 3);
    end
    eff = (cap_len < 0) ? 20 : cap_len;
    for (int k = 1; k <= eff; k++) begin
      n_cmp++;
      if (cap_en[k] !== (k <= n + 2) || cap_ld[k] !== (k == 2)) begin
        n_bad++;
        $display("FAIL %s en/load at T+%0d: got %b/%b want %b/%b", name, k, cap_en[k], cap_ld[k], k <= n + 2, k == 2);
      end
      if (k <= n) begin
        n_cmp++;
        if (int'(cap_col[k]) != ecol[k-1] || cap_msb[k] !== (ecol[k-1] == 7)) begin
          n_bad++;
          $display("FAIL %s column at T+%0d: got %0d msb %b want %0d", name, k, cap_col[k], cap_msb[k], ecol[k-1]);
        end
      end else if (k <= n + 2) begin
        n_cmp++;
        if (cap_val[k] !== 8'h00 || cap_skip[k] !== 2'b11) begin
          n_bad++;
          $display("FAIL %s drain at T+%0d: got val %h skip %b want 00/11", name, k, cap_val[k], cap_skip[k]);
        end
      end
    end
    acc = 0;
    for (int k = 1; k <= n && k <= eff; k++) begin
      int c, csum, s, idx, lane;
      c = int'(cap_col[k]);
      csum = 0;
      for (int g = 0; g < 2; g++) begin
        s = 0;
        for (int j = 0; j < 4; j++) begin
          lane = 4 * g + j;
          if (cap_val[k][lane]) begin
            idx = 8 * g + j + int'(cap_sel[k][lane]);
            if (idx <= 8 * g + 7) s += tile_act[idx];
          end
        end
        csum += cap_skip[k][g] ? s : gsum[g] - s;
      end
      acc += ((c == 7) ? -128 : (1 << c)) * csum;
    end
    n_cmp++;
    if (acc != gold) begin
      n_bad++;
      $display("FAIL %s mac result: got %0d want %0d", name, acc, gold);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if ({mac_en, is_msb, load_accum, result_valid, act_val, is_skip_zero, column_idx, act_sel} !== '0) begin
      n_bad++;
      $display("FAIL %s controls: got en%b msb%b ld%b rv%b val%h skip%b col%0d sel%h want all 0",
               name, mac_en, is_msb, load_accum, result_valid, act_val, is_skip_zero, column_idx, act_sel);
    end
    n_cmp++;
    if (act !== '0 || sum_act !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s data/ready: got act %h sum %h rdy %b want 0/0/1", name, act, sum_act, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; act_in = '0; w_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_zero_weights();
    rand_acts();
    for (int i = 0; i < 16; i++) tile_w[i] = 0;
    run_tile("zero_w");
    n_cmp++;
    if (cap_col[1] !== 3'd0 || cap_val[1] !== 8'h00) begin
      n_bad++;
      $display("FAIL zero_w issue: got col %0d val %h want 0/00", cap_col[1], cap_val[1]);
    end
  endtask

  task automatic test_two_targets();
    rand_acts();
    for (int i = 0; i < 16; i++) tile_w[i] = 0;
    tile_w[0] = 8; tile_w[7] = 8;
    step();
    run_tile("two_targets");
    n_cmp++;
    if (cap_col[1] !== 3'd3 || cap_skip[1] !== 2'b11 || cap_val[1] !== 8'h09 ||
        cap_sel[1][0] !== 3'd0 || cap_sel[1][3] !== 3'd4) begin
      n_bad++;
      $display("FAIL two_targets encode: got col %0d skip %b val %h sel0 %0d sel3 %0d want 3/11/09/0/4",
               cap_col[1], cap_skip[1], cap_val[1], cap_sel[1][0], cap_sel[1][3]);
    end
  endtask

  task automatic test_skip_zero();
    rand_acts();
    tile_w[0] = 0;
    for (int i = 1; i < 16; i++) tile_w[i] = 32;
    step();
    run_tile("skip_zero");
    n_cmp++;
    if (cap_col[1] !== 3'd5 || cap_skip[1] !== 2'b00 || cap_val[1] !== 8'h01 || cap_sel[1][0] !== 3'd0) begin
      n_bad++;
      $display("FAIL skip_zero encode: got col %0d skip %b val %h sel0 %0d want 5/00/01/0",
               cap_col[1], cap_skip[1], cap_val[1], cap_sel[1][0]);
    end
  endtask

  task automatic test_all_neg();
    int msb_cnt;
    rand_acts();
    for (int i = 0; i < 16; i++) tile_w[i] = -1;
    step();
    run_tile("all_neg");
    msb_cnt = 0;
    for (int k = 1; k <= 11; k++) msb_cnt += int'(cap_msb[k]);
    n_cmp++;
    if (msb_cnt != 1 || cap_msb[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL all_neg is_msb: got count %0d first %b want 1/1", msb_cnt, cap_msb[1]);
    end
  endtask

  task automatic test_sparse_05();
    rand_acts();
    for (int i = 0; i < 16; i++) tile_w[i] = 5;
    step();
    run_tile("w05");
    n_cmp++;
    if (cap_len != 5 || cap_skip[1] !== 2'b00 || cap_skip[2] !== 2'b00 ||
        cap_val[1] !== 8'h00 || cap_val[2] !== 8'h00) begin
      n_bad++;
      $display("FAIL w05 columns: got len %0d skip %b,%b val %h,%h want 5/00,00/00,00",
               cap_len, cap_skip[1], cap_skip[2], cap_val[1], cap_val[2]);
    end
  endtask

  task automatic test_reset_mid_tile();
    rand_acts();
    for (int i = 0; i < 16; i++) begin
      tile_w[i] = -1;
      act_in[i] = 8'(tile_act[i]);
      w_in[i]   = 8'hFF;
    end
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("mid_reset");
    rand_acts();
    run_tile("after_reset");
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 16; i++) begin tile_act[i] = -128; tile_w[i] = -128; end
    step();
    run_tile("min_min");
    for (int i = 0; i < 16; i++) begin tile_act[i] = 127; tile_w[i] = 127; end
    step();
    run_tile("max_max");
  endtask

  task automatic test_random();
    int mask;
    for (int t = 0; t < 40; t++) begin
      rand_acts();
      mask = int'($urandom_range(255));
      for (int i = 0; i < 16; i++) begin
        tile_w[i] = int'($urandom_range(255)) & mask;
        if (tile_w[i] > 127) tile_w[i] -= 256;
      end
      repeat ($urandom_range(2)) step();
      run_tile("random");
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      rand_acts();
      for (int i = 0; i < 16; i++) tile_w[i] = int'($urandom_range(255)) - 128;
      run_tile("back_to_back");
    end
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_two_targets();
    test_skip_zero();
    test_all_neg();
    test_sparse_05();
    test_reset_mid_tile();
    test_extremes();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
